// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the fetch PC sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} pc_state_t;
  localparam int PC_INC = 4;
endpackage

// File: rtl/register.sv
// register: n-bit load-enabled storage register, async active-high reset to 0.
module register #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) Q <= '0;
    else if (load) Q <= D;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage next-PC selection with stall, branch/jump redirect and IF/ID flush.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         fetch_valid,
  output logic         flush
);
  pc_state_t state_q, state_d;
  logic [N-1:0] sel_target, target, pend_q, pc_d;
  logic redir, active, pc_load, pend_load;
  assign redir = branch_taken | jump;
  // Branch is older than the jump in ID, so it takes priority.
  assign sel_target = branch_taken ? branch_target : jump_target;
  assign target = {sel_target[N-1:2], 2'b00};
  assign active = (state_q == RUN) || (state_q == HOLD);
  assign fetch_valid = active;
  assign flush = active & redir;
  assign pc_load = active & ~stall;
  assign pend_load = active & stall & redir;
  assign pc_plus4 = pc + N'(PC_INC);
  always_comb begin
    pc_d = redir ? target : (state_q == HOLD) ? pend_q : pc_plus4;
    state_d = (state_q == BOOT) ? RUN :
              (state_q == RUN) ? ((stall & redir) ? HOLD : RUN) :
              (stall ? HOLD : RUN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= BOOT;
    else state_q <= state_d;
  register #(.n(N)) u_pc (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .D   (pc_d),
    .Q   (pc)
  );
  // Holds a redirect taken while stalled until fetch may advance.
  register #(.n(N)) u_pend (
    .clk (clk),
    .rst (rst),
    .load(pend_load),
    .D   (target),
    .Q   (pend_q)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector self-checking bench for pc_sequencer (N=32 and N=8).
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic stall, bt, jp;
  logic [31:0] bta, jta, pc, pc4;
  logic fv, flush;
  logic jp8;
  logic [7:0] jt8, pc8, pc48;
  logic fv8, flush8;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.N(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(bt), .branch_target(bta),
    .jump(jp), .jump_target(jta),
    .pc(pc), .pc_plus4(pc4), .fetch_valid(fv), .flush(flush)
  );

  pc_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(jp8), .jump_target(jt8),
    .pc(pc8), .pc_plus4(pc48), .fetch_valid(fv8), .flush(flush8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; bt = 0; jp = 0; bta = 0; jta = 0; jp8 = 0; jt8 = 0;
    #2;
    check("rst_pc", pc, 0);
    check("rst_fv", {31'd0, fv}, 0);
    check("rst_flush", {31'd0, flush}, 0);
    step(); rst = 0; #1;
    check("boot_pc", pc, 0);
    check("boot_fv", {31'd0, fv}, 0);
    step();
    check("run_pc0", pc, 0);
    check("run_fv", {31'd0, fv}, 1);
    check("run_flush", {31'd0, flush}, 0);
    check("pc_plus4", pc4, 4);
    jp8 = 1; jt8 = 8'hFB; #1;
    check("n8_flush", {31'd0, flush8}, 1);
    step(); jp8 = 0;
    check("seq_4", pc, 4);
    check("n8_pc_f8", {24'd0, pc8}, 32'hF8);
    step();
    check("seq_8", pc, 8);
    check("n8_pc_fc", {24'd0, pc8}, 32'hFC);
    check("n8_plus4_wrap", {24'd0, pc48}, 0);
    step();
    check("seq_12", pc, 12);
    check("n8_pc_wrap", {24'd0, pc8}, 0);
    check("n8_fv_wrap", {31'd0, fv8}, 1);
    step();
    check("seq_16", pc, 32'h10);
    check("seq_flush", {31'd0, flush}, 0);
    // Simultaneous branch and jump: branch wins.
    bt = 1; bta = 32'h40; jp = 1; jta = 32'h80; #1;
    check("both_flush", {31'd0, flush}, 1);
    step(); bt = 0; jp = 0;
    check("both_pc", pc, 32'h40);
    jp = 1; jta = 32'h20; step(); jp = 0;
    check("jump_pc", pc, 32'h20);
    // Three-cycle stall with a jump in the second cycle.
    stall = 1; #1;
    check("st1_flush", {31'd0, flush}, 0);
    step();
    check("st1_pc", pc, 32'h20);
    jp = 1; jta = 32'h103; #1;
    check("st2_flush", {31'd0, flush}, 1);
    step(); jp = 0; #1;
    check("st3_flush", {31'd0, flush}, 0);
    check("st2_pc", pc, 32'h20);
    check("hold_fv", {31'd0, fv}, 1);
    step(); stall = 0; #1;
    check("st3_pc", pc, 32'h20);
    check("rel_flush", {31'd0, flush}, 0);
    step();
    check("rel_pc", pc, 32'h100);
    // HOLD overwrite of the pending target while still stalled.
    stall = 1; jp = 1; jta = 32'h100; step(); jp = 0;
    bt = 1; bta = 32'h200; #1;
    check("ovr_flush", {31'd0, flush}, 1);
    step(); bt = 0; stall = 0;
    check("ovr_pc_held", pc, 32'h100);
    step();
    check("ovr_pc", pc, 32'h200);
    // HOLD release with a fresh redirect in the same cycle.
    stall = 1; jp = 1; jta = 32'h300; step();
    stall = 0; jta = 32'h404; #1;
    check("hrel_flush", {31'd0, flush}, 1);
    step(); jp = 0;
    check("hrel_pc", pc, 32'h404);
    // Reset in the middle of HOLD drops the pending target.
    stall = 1; jp = 1; jta = 32'h500; step(); jp = 0;
    check("mh_pc", pc, 32'h404);
    #2 rst = 1; #1;
    check("mh_rst_pc", pc, 0);
    check("mh_rst_fv", {31'd0, fv}, 0);
    stall = 0;
    step(); rst = 0; #1;
    check("mh_boot_fv", {31'd0, fv}, 0);
    step();
    check("mh_pc0", pc, 0);
    check("mh_fv", {31'd0, fv}, 1);
    step();
    check("mh_pc4", pc, 4);
    step();
    check("mh_pc8", pc, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter sequencer for the pipelined core. It computes the next PC each cycle and drives the load-enabled storage register that holds the PC. Inputs are stall, branch redirect (EX) and jump redirect (ID). Outputs are the current fetch address, a fetch-valid qualifier and a flush pulse for the IF/ID pipeline register.

## Interface
- `N`, 32, PC width in bits; must be ≥ 3.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit holds fetch; PC must not advance.
- `branch_taken`  in  1  EX-stage branch resolved taken this cycle.
- `branch_target`  in  N  branch destination.
- `jump`  in  1  ID-stage unconditional jump this cycle.
- `jump_target`  in  N  jump destination.
- `pc`  out  N  current fetch address.
- `pc_plus4`  out  N  `pc + 4`, combinational, modulo 2^N.
- `fetch_valid`  out  1  `pc` is a real fetch this cycle.
- `flush`  out  1  kill the instruction in IF/ID; combinational.

## Operation
- Reset values:
  - `pc` = 0.
  - pending target = 0.
  - state = BOOT.
  - `fetch_valid` = 0.
  - `flush` = 0.
- Redirect request: `redir = branch_taken | jump`.
  - Target is `branch_target` if `branch_taken`, else `jump_target`. The branch is the older instruction, so it wins when both are asserted.
  - Bits [1:0] of every target are forced to 00 before use.
- States:
  - BOOT: `fetch_valid` = 0 and `pc` holds. Go to RUN on the next edge regardless of inputs; redirects are ignored in BOOT.
  - RUN, `stall`=0, `redir`=0: `pc <= pc_plus4`.
  - RUN, `stall`=0, `redir`=1: `pc <= target`; `flush` = 1 this cycle; stay in RUN.
  - RUN, `stall`=1, `redir`=0: `pc` holds.
  - RUN, `stall`=1, `redir`=1: `pc` holds; pending <= target; `flush` = 1; go to HOLD.
  - HOLD, `stall`=1: `pc` holds. A new `redir` overwrites pending, using the same priority, and asserts `flush` again.
  - HOLD, `stall`=0: `pc <= pending`, or the new target if `redir`=1 this cycle, in which case `flush` = 1. Go to RUN.
- `fetch_valid` = 1 in RUN and HOLD; `fetch_valid` = 0 in BOOT.
- Wrap-around: `pc_plus4` from `2^N − 4` is 0; no error is flagged.
- Asserting `rst` in any state forces reset values immediately, including mid-HOLD. The pending target is lost.

## Timing
- Next-PC latency is 1 cycle: a redirect sampled at edge k appears on `pc` after edge k, except in HOLD.
- `flush` is combinational from `branch_taken`, `jump`, `stall` and state. It is asserted in the cycle the redirect is sampled, never later.
- A stall-then-redirect sequence costs exactly one flush and no lost target. Stall cycles only add hold cycles.
- After `rst` deasserts, the first edge is spent in BOOT. The first valid fetch is `pc` = 0, presented in the following cycle.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_state_t` {BOOT, RUN, HOLD}.
  - constant `PC_INC` = 4.
- PC storage: instantiate the team's existing n-bit load-enabled `register` with `n = N`.
  - `load` = advance condition.
  - `D` = next-PC mux output.
- The pending-target storage is a second `register` instance, loaded on redirect while stalled.
- The FSM and next-PC mux stay in `pc_sequencer` itself; no further sub-modules.

## Test plan
- Reset, then 4 free-running cycles: `pc` sequence 0 (fetch_valid=0, BOOT), 0, 4, 8, 12; `flush` stays 0.
- At `pc`=0x10, assert `branch_taken` with target 0x40 and `jump` with target 0x80 together: `flush`=1 that cycle; next `pc`=0x40.
- Hold `stall` for 3 cycles at `pc`=0x20; assert `jump` to 0x103 in stall cycle 2. Required response:
  - `flush`=1 in that cycle only.
  - `pc` stays 0x20 while stalled.
  - `pc`=0x100 after stall drops.
- In HOLD with pending 0x100, assert `branch_taken` to 0x200 while still stalled: pending becomes 0x200; `pc`=0x200 after stall drops.
- With N=8, run from `pc`=0xF8: sequence 0xF8, 0xFC, 0x00, no error.
- Assert `rst` mid-HOLD: `pc`=0 and `fetch_valid`=0 immediately; after release, BOOT then 0, 4; the old pending target is never fetched.
